tally_reporter: RTL and testbench
=================================

TALLY_REPORTER -- requirements
Module: tally_reporter

Interface
REQ-001 clk  input  1  single clock; all logic on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 results_valid  input  1  tally closed; vote/winner inputs are final and stable.
REQ-004 report_req  input  1  single-cycle request to transmit one result frame.
REQ-005 vote0, vote1, vote2, vote3  input  8 each  candidate tallies from the voting machine.
REQ-006 winner_index  input  2  winning candidate index.
REQ-007 winner_votes  input  8  winning candidate tally.
REQ-008 tx_data  output  8  current frame byte.
REQ-009 tx_valid  output  1  tx_data valid; held until accepted.
REQ-010 tx_ready  input  1  downstream accepts the byte when tx_valid and tx_ready are both 1 at a rising edge.
REQ-011 busy  output  1  high while a frame is in progress.
REQ-012 done  output  1  one-cycle pulse after the last byte is accepted.
REQ-013 reject  output  1  one-cycle pulse when a request is refused.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SEND, FINISH.
REQ-015 IDLE, report_req=1, results_valid=1 at edge N SHALL snapshot all tally inputs, enter SEND, and zero the byte index. From cycle N+1: busy=1, tx_valid=1, tx_data=0xA5.
REQ-016 IDLE, report_req=1, results_valid=0 at edge N SHALL pulse reject for cycle N+1 only and remain in IDLE.
REQ-017 The frame SHALL be 8 bytes in this order: 0xA5, vote0, vote1, vote2, vote3, {6'b0, winner_index}, winner_votes, checksum.
REQ-018 The checksum SHALL be the bitwise XOR of bytes 0-6, including the header.
REQ-019 All frame bytes SHALL come from the snapshot; input changes after acceptance SHALL NOT alter the frame.
REQ-020 On each edge with tx_valid and tx_ready both 1, the byte index SHALL increment and the next byte SHALL appear in the following cycle, with no bubble.
REQ-021 While tx_valid=1 and tx_ready=0, tx_data SHALL be held stable and tx_valid SHALL stay high.
REQ-022 With tx_ready tied high, the frame SHALL occupy exactly 8 consecutive cycles.
REQ-023 After byte 7 is accepted at edge M, the block SHALL enter FINISH. In cycle M+1: tx_valid=0, done=1, busy=0. It SHALL then return to IDLE at edge M+1.
REQ-024 A report_req at the FINISH edge (M+1) SHALL be accepted as in REQ-015, giving back-to-back frames.
REQ-025 report_req while in SEND SHALL be ignored: no reject and no effect on the current frame.
REQ-026 A drop of results_valid mid-frame SHALL NOT abort the frame.
REQ-027 tx_data SHALL be 0x00 whenever tx_valid=0.
REQ-028 done and reject SHALL never be high in the same cycle.

Reset
REQ-029 reset=1 at any edge SHALL force IDLE in the next cycle, with tx_valid=0, tx_data=0x00, busy=0, done=0, reject=0, byte index=0, and snapshot registers=0.
REQ-030 reset mid-frame SHALL discard the frame; no done pulse SHALL follow.
REQ-031 reset SHALL take priority over report_req in the same cycle.

Verification
REQ-032 Basic frame: votes 2,1,3,0; winner_index=2; winner_votes=3; tx_ready=1; pulse report_req -> tx_data A5,02,01,03,00,02,03,A4 on 8 consecutive cycles, then done=1 for 1 cycle.
REQ-033 Backpressure: same inputs, tx_ready=0 for 3 cycles while 0x01 is presented -> 0x01 held for 4 cycles, frame contents unchanged, done 3 cycles later than in REQ-032.
REQ-034 Reject: results_valid=0, report_req pulse -> reject=1 for one cycle, tx_valid stays 0, busy stays 0.
REQ-035 Snapshot: change vote0 from 2 to 9 one cycle after acceptance -> byte 1 is still 0x02 and the checksum is still 0xA4.
REQ-036 Reset mid-frame: assert reset after byte 3 is accepted -> tx_valid=0 and busy=0 the next cycle, no done; a new report_req then sends a full frame starting with 0xA5.
REQ-037 Ignored request: report_req pulsed during SEND -> no reject, exactly one 8-byte frame, one done pulse.

Source files
------------

// File: rtl/tally_reporter.sv
// Result-frame transmitter: snapshots the closed tally and sends an
// 8-byte checksummed frame over a valid/ready byte stream.
module tally_reporter (
    input  logic       clk,
    input  logic       reset,
    input  logic       results_valid,
    input  logic       report_req,
    input  logic [7:0] vote0,
    input  logic [7:0] vote1,
    input  logic [7:0] vote2,
    input  logic [7:0] vote3,
    input  logic [1:0] winner_index,
    input  logic [7:0] winner_votes,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       reject
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [7:0] HEADER = 8'hA5;

    state_t     state;
    state_t     state_next;
    logic [2:0] byte_idx;
    logic [7:0] snap_v0;
    logic [7:0] snap_v1;
    logic [7:0] snap_v2;
    logic [7:0] snap_v3;
    logic [1:0] snap_wi;
    logic [7:0] snap_wv;
    logic [7:0] checksum;
    logic [7:0] frame_byte;
    logic       accept;
    logic       refuse;
    logic       last_taken;

    // FINISH behaves like IDLE for new requests so frames can run back to back.
    assign accept     = (state != SEND) && report_req && results_valid;
    assign refuse     = (state != SEND) && report_req && !results_valid;
    assign last_taken = (state == SEND) && tx_ready && (byte_idx == 3'd7);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, FINISH: state_next = accept ? SEND : IDLE;
            SEND:         if (last_taken) state_next = FINISH;
            default:      state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_idx <= 3'd0;
            snap_v0  <= 8'h00;
            snap_v1  <= 8'h00;
            snap_v2  <= 8'h00;
            snap_v3  <= 8'h00;
            snap_wi  <= 2'd0;
            snap_wv  <= 8'h00;
            reject   <= 1'b0;
        end else begin
            reject <= refuse;
            if (accept) begin
                byte_idx <= 3'd0;
                snap_v0  <= vote0;
                snap_v1  <= vote1;
                snap_v2  <= vote2;
                snap_v3  <= vote3;
                snap_wi  <= winner_index;
                snap_wv  <= winner_votes;
            end else if (state == SEND && tx_ready) begin
                byte_idx <= byte_idx + 3'd1;
            end
        end
    end

    assign checksum = HEADER ^ snap_v0 ^ snap_v1 ^ snap_v2 ^ snap_v3
                    ^ {6'b0, snap_wi} ^ snap_wv;

    always_comb begin
        frame_byte = 8'h00;
        unique case (byte_idx)
            3'd0: frame_byte = HEADER;
            3'd1: frame_byte = snap_v0;
            3'd2: frame_byte = snap_v1;
            3'd3: frame_byte = snap_v2;
            3'd4: frame_byte = snap_v3;
            3'd5: frame_byte = {6'b0, snap_wi};
            3'd6: frame_byte = snap_wv;
            3'd7: frame_byte = checksum;
            default: frame_byte = 8'h00;
        endcase
    end

    assign tx_valid = (state == SEND);
    assign busy     = (state == SEND);
    assign done     = (state == FINISH);
    assign tx_data  = tx_valid ? frame_byte : 8'h00;

endmodule

// File: tb/tb_tally_reporter.sv
// Directed bench for tally_reporter: frames, backpressure, reject,
// snapshot isolation, reset mid-frame and ignored requests.
module tb_tally_reporter;

    logic       clk = 1'b0;
    logic       reset;
    logic       results_valid;
    logic       report_req;
    logic [7:0] vote0, vote1, vote2, vote3;
    logic [1:0] winner_index;
    logic [7:0] winner_votes;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       reject;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_frame [8];

    tally_reporter dut (
        .clk           (clk),
        .reset         (reset),
        .results_valid (results_valid),
        .report_req    (report_req),
        .vote0         (vote0),
        .vote1         (vote1),
        .vote2         (vote2),
        .vote3         (vote3),
        .winner_index  (winner_index),
        .winner_votes  (winner_votes),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .done          (done),
        .reject        (reject)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the first frame cycle; returns in the done cycle.
    task automatic frame_check(input int stall_at, input int stalls,
                               input int req_at);
        int cyc;
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == stall_at) begin
                tx_ready = 1'b0;
                for (int s = 0; s < stalls; s++) begin
                    check($sformatf("hold%0d_%0d", i, s), tx_data,
                          exp_frame[i]);
                    check("hold_valid", {7'b0, tx_valid}, 8'd1);
                    tick();
                    cyc++;
                end
                tx_ready = 1'b1;
            end
            if (i == req_at) report_req = 1'b1;
            check($sformatf("byte%0d", i), tx_data, exp_frame[i]);
            check("valid", {7'b0, tx_valid}, 8'd1);
            check("busy", {7'b0, busy}, 8'd1);
            check("no_done", {7'b0, done}, 8'd0);
            check("no_reject", {7'b0, reject}, 8'd0);
            tick();
            cyc++;
            report_req = 1'b0;
        end
        check("frame_cycles", 8'(cyc), 8'(8 + stalls));
        check("done", {7'b0, done}, 8'd1);
        check("end_valid", {7'b0, tx_valid}, 8'd0);
        check("end_busy", {7'b0, busy}, 8'd0);
        check("end_data", tx_data, 8'h00);
        check("end_reject", {7'b0, reject}, 8'd0);
    endtask

    task automatic start_frame();
        report_req = 1'b1;
        tick();
        report_req = 1'b0;
    endtask

    task automatic after_done();
        tick();
        check("done_pulse", {7'b0, done}, 8'd0);
        check("idle_busy", {7'b0, busy}, 8'd0);
    endtask

    initial begin
        exp_frame = '{8'hA5, 8'h02, 8'h01, 8'h03,
                      8'h00, 8'h02, 8'h03, 8'hA4};
        reset = 1'b1;
        results_valid = 1'b0;
        report_req = 1'b0;
        tx_ready = 1'b1;
        vote0 = 8'd2; vote1 = 8'd1; vote2 = 8'd3; vote3 = 8'd0;
        winner_index = 2'd2;
        winner_votes = 8'd3;
        tick();
        tick();
        reset = 1'b0;
        check("rst_valid", {7'b0, tx_valid}, 8'd0);
        check("rst_data", tx_data, 8'h00);
        check("rst_busy", {7'b0, busy}, 8'd0);
        check("rst_done", {7'b0, done}, 8'd0);
        check("rst_reject", {7'b0, reject}, 8'd0);

        // Basic frame
        results_valid = 1'b1;
        start_frame();
        frame_check(-1, 0, -1);
        after_done();

        // Backpressure on 0x01 for 3 cycles
        start_frame();
        frame_check(2, 3, -1);
        after_done();

        // Reject when results are not valid
        results_valid = 1'b0;
        report_req = 1'b1;
        tick();
        report_req = 1'b0;
        check("reject", {7'b0, reject}, 8'd1);
        check("rej_valid", {7'b0, tx_valid}, 8'd0);
        check("rej_busy", {7'b0, busy}, 8'd0);
        check("rej_done", {7'b0, done}, 8'd0);
        tick();
        check("reject_pulse", {7'b0, reject}, 8'd0);
        check("rej_busy2", {7'b0, busy}, 8'd0);
        results_valid = 1'b1;

        // Snapshot isolation, plus a drop of results_valid mid-frame
        start_frame();
        vote0 = 8'd9;
        results_valid = 1'b0;
        frame_check(-1, 0, -1);
        vote0 = 8'd2;
        results_valid = 1'b1;
        after_done();

        // Back-to-back: request in the done cycle
        start_frame();
        frame_check(-1, 0, -1);
        start_frame();
        frame_check(-1, 0, -1);
        after_done();

        // Reset after byte 3 is accepted
        start_frame();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("pre_rst%0d", i), tx_data, exp_frame[i]);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_valid", {7'b0, tx_valid}, 8'd0);
        check("mrst_busy", {7'b0, busy}, 8'd0);
        check("mrst_data", tx_data, 8'h00);
        check("mrst_done", {7'b0, done}, 8'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mrst_nodone", {7'b0, done}, 8'd0);
        end
        start_frame();
        frame_check(-1, 0, -1);
        after_done();

        // Reset wins over a simultaneous request
        reset = 1'b1;
        report_req = 1'b1;
        tick();
        reset = 1'b0;
        report_req = 1'b0;
        check("prio_busy", {7'b0, busy}, 8'd0);
        check("prio_valid", {7'b0, tx_valid}, 8'd0);
        tick();
        check("prio_busy2", {7'b0, busy}, 8'd0);

        // Request during SEND is ignored
        start_frame();
        frame_check(-1, 0, 3);
        after_done();
        tick();
        check("ign_idle", {7'b0, tx_valid}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
